lnrv_icb_arbiter: RTL and testbench
===================================

// Module: lnrv_icb_arbiter
// PURPOSE
//  N-to-1 ICB arbiter. It merges P_ICB_COUNT master ICB ports (core fetch, LSU, debug, DMA) onto one ICB port.
//  That port feeds the address-decoding ICB demux on the system bus.
//  Round-robin command arbitration; per-command grant record kept in an in-order outstanding FIFO to route responses.
// PARAMETERS
//  P_ADDR_WIDTH   32  address width
//  P_DATA_WIDTH   32  data width; wstrb width = P_DATA_WIDTH/8
//  P_ICB_COUNT    4   number of master ports, >= 2
//  P_OTS_COUNT    2   max outstanding commands (FIFO depth), >= 1
// PORTS
//  clk               in   1           clock
//  reset_n           in   1           synchronous, active-low reset
//  mn_icb_cmd_vld    in   N           per-master cmd valid
//  mn_icb_cmd_rdy    out  N           per-master cmd ready
//  mn_icb_cmd_write  in   N           per-master write flag
//  mn_icb_cmd_addr   in   N*AW        packed, master i at [i*AW +: AW]
//  mn_icb_cmd_wdata  in   N*DW        packed write data
//  mn_icb_cmd_wstrb  in   N*DW/8      packed byte strobes
//  mn_icb_rsp_vld    out  N           per-master rsp valid
//  mn_icb_rsp_rdy    in   N           per-master rsp ready
//  mn_icb_rsp_rdata  out  N*DW        packed read data, zero when not selected
//  mn_icb_rsp_err    out  N           per-master rsp error
//  s_icb_cmd_vld     out  1           merged cmd to downstream
//  s_icb_cmd_rdy     in   1
//  s_icb_cmd_write   out  1
//  s_icb_cmd_addr    out  AW
//  s_icb_cmd_wdata   out  DW
//  s_icb_cmd_wstrb   out  DW/8
//  s_icb_rsp_vld     in   1
//  s_icb_rsp_rdy     out  1
//  s_icb_rsp_rdata   in   DW
//  s_icb_rsp_err     in   1
// BEHAVIOUR
//  - Reset, synchronous on reset_n=0 at clk edge: rr_ptr=0, lock=0, lock_idx=0, FIFO empty.
//    Consequently all mn_icb_rsp_vld=0, s_icb_rsp_rdy=0, and s_icb_cmd_vld=0 while no master is valid.
//  - Arbitration is combinational, 0-cycle latency cmd path.
//    Among asserted mn_icb_cmd_vld, grant the first index at or above rr_ptr, wrapping modulo N.
//  - Lock: if s_icb_cmd_vld=1 and s_icb_cmd_rdy=0, set lock=1 and lock_idx=grant.
//    While locked, grant=lock_idx regardless of other requests. Clear lock on handshake.
//    Granted masters must hold vld and payload stable until rdy.
//  - On cmd handshake by master k: rr_ptr <= (k+1) mod N, and push one-hot grant into the FIFO.
//  - Cmd gating: s_icb_cmd_vld = |mn_icb_cmd_vld & ~fifo_full.
//    mn_icb_cmd_rdy[k] = grant[k] & s_icb_cmd_rdy & ~fifo_full.
//    Full blocks commands even if a pop occurs in the same cycle; there is no rsp->cmd comb path.
//  - s_icb_cmd_* payload = granted master's fields; all zero when nothing is granted.
//  - Rsp routing uses the FIFO head one-hot h:
//    mn_icb_rsp_vld = h & {N{s_icb_rsp_vld & ~fifo_empty}}.
//    s_icb_rsp_rdy = |(h & mn_icb_rsp_rdy) & ~fifo_empty.
//    rdata/err are forwarded only to the selected master; other masters see zero.
//    Pop on rsp handshake.
//  - FIFO empty: no bypass. A rsp arriving in the same cycle as the first cmd handshake is not accepted (rdy=0).
//    A rsp arriving with the FIFO empty is a protocol violation: it is held off and never acknowledged.
//  - Simultaneous push and pop with FIFO not full: both take effect, count unchanged.
//  - Pointer wrap: rr_ptr after a grant to N-1 is 0.
//  - Reset mid-transaction: all state is discarded; in-flight responses are not tracked.
// STRUCTURE
//  - Shared header lnrv_icb_defines.vh: default AW/DW, and clog2 macro for the index width.
//  - Sub-module: lnrv_gnrl_buffer as the outstanding FIFO.
//    Settings: P_DATA_WIDTH=N, P_DEEPTH=P_OTS_COUNT, P_CUT_READY="true", P_BYPASS="false"; flush_req tied to 0.
//  - Local logic: round-robin priority select (double-width request trick), lock register, payload AND-OR mux.
// TESTING
//  1. N=4, OTS=2. Only master0 writes addr 0x1000, wdata 0xA5A5A5A5, slave rdy=1.
//     -> handshake in the same cycle; 1 cycle later rsp rdata 0x0 to mn0 only.
//  2. Masters 0,1,2 hold vld, slave always ready and responding.
//     -> grant sequence 0,1,2,0,1,2; master3 is never granted.
//  3. Master0 granted, slave rdy=0 for 3 cycles, master1 raises vld in cycle 1.
//     -> grant stays 0 until handshake; master1 granted next cycle.
//  4. OTS=2, slave accepts but withholds rsp. -> after 2 handshakes all mn rdy=0.
//     Then one rsp handshake -> the next cmd is accepted the cycle after the pop.
//  5. Cmds from m1 then m3; rsp rdata 0xDEADBEEF with mn1_rsp_rdy=0 for 2 cycles.
//     -> s_icb_rsp_rdy=0 and mn1 holds 0xDEADBEEF; mn3 receives the second rsp only after mn1 accepts.
//  6. reset_n=0 for 1 cycle with 2 outstanding and rr_ptr=2.
//     -> next cycle FIFO empty, rr_ptr=0, all mn rsp_vld=0, master0 has highest priority.

Source files
------------

// File: rtl/lnrv_icb_arbiter_pkg.sv
// Shared constants and helpers for the ICB arbiter slice.
// Holds the default bus widths and the index-width helper.
package lnrv_icb_arbiter_pkg;

   localparam int ICB_AW_DEF = 32;
   localparam int ICB_DW_DEF = 32;

   // Index width for v entries, never below 1 bit so that
   // single-entry structures still get a legal pointer.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

endpackage

// File: rtl/lnrv_gnrl_buffer.sv
// Generic valid/ready FIFO used to record outstanding grants.
// Ports: clk, reset_n (sync, active-low), flush_req,
//   i_vld/i_rdy/i_data (write side), o_vld/o_rdy/o_data (read side).
module lnrv_gnrl_buffer
   import lnrv_icb_arbiter_pkg::*;
#(
   parameter int    P_DATA_WIDTH = 8,
   parameter int    P_DEEPTH     = 2,
   parameter string P_CUT_READY  = "true",
   parameter string P_BYPASS     = "false"
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    flush_req,
   input  logic                    i_vld,
   output logic                    i_rdy,
   input  logic [P_DATA_WIDTH-1:0] i_data,
   output logic                    o_vld,
   input  logic                    o_rdy,
   output logic [P_DATA_WIDTH-1:0] o_data
);

   localparam int  PW  = clog2_min1(P_DEEPTH);
   localparam int  CW  = clog2_min1(P_DEEPTH + 1);
   localparam bit  CUT = (P_CUT_READY == "true");
   localparam bit  BYP = (P_BYPASS == "true");

   logic [P_DATA_WIDTH-1:0] mem [0:P_DEEPTH-1];
   logic [PW-1:0]           wptr;
   logic [PW-1:0]           rptr;
   logic [CW-1:0]           cnt;
   logic                    full;
   logic                    empty;
   logic                    byp_go;
   logic                    push;
   logic                    pop;

   assign full  = (cnt == CW'(P_DEEPTH));
   assign empty = (cnt == '0);

   // Bypass: an empty buffer presents the incoming entry directly.
   assign byp_go = BYP & empty & i_vld;

   assign o_vld  = ~empty | byp_go;
   assign o_data = (BYP && empty) ? i_data : mem[rptr];

   // Cut-ready keeps i_rdy a pure function of the fill level.
   assign i_rdy = CUT ? ~full : (~full | o_rdy);

   assign push = i_vld & i_rdy & ~(byp_go & o_rdy);
   assign pop  = ~empty & o_rdy;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(P_DEEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n || flush_req) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= inc(wptr);
         if (pop)  rptr <= inc(rptr);
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (!push && pop) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= i_data;
   end

endmodule

// File: rtl/lnrv_icb_arbiter.sv
// N-to-1 round-robin ICB arbiter with in-order response routing.
// Ports: clk, reset_n (sync, active-low); mn_icb_* packed master
//   side (master i at slice i); s_icb_* merged downstream port.
module lnrv_icb_arbiter
   import lnrv_icb_arbiter_pkg::*;
#(
   parameter int P_ADDR_WIDTH = ICB_AW_DEF,
   parameter int P_DATA_WIDTH = ICB_DW_DEF,
   parameter int P_ICB_COUNT  = 4,
   parameter int P_OTS_COUNT  = 2
)(
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [P_ICB_COUNT-1:0]              mn_icb_cmd_vld,
   output logic [P_ICB_COUNT-1:0]              mn_icb_cmd_rdy,
   input  logic [P_ICB_COUNT-1:0]              mn_icb_cmd_write,
   input  logic [P_ICB_COUNT*P_ADDR_WIDTH-1:0] mn_icb_cmd_addr,
   input  logic [P_ICB_COUNT*P_DATA_WIDTH-1:0] mn_icb_cmd_wdata,
   input  logic [P_ICB_COUNT*P_DATA_WIDTH/8-1:0] mn_icb_cmd_wstrb,
   output logic [P_ICB_COUNT-1:0]              mn_icb_rsp_vld,
   input  logic [P_ICB_COUNT-1:0]              mn_icb_rsp_rdy,
   output logic [P_ICB_COUNT*P_DATA_WIDTH-1:0] mn_icb_rsp_rdata,
   output logic [P_ICB_COUNT-1:0]              mn_icb_rsp_err,
   output logic                                s_icb_cmd_vld,
   input  logic                                s_icb_cmd_rdy,
   output logic                                s_icb_cmd_write,
   output logic [P_ADDR_WIDTH-1:0]             s_icb_cmd_addr,
   output logic [P_DATA_WIDTH-1:0]             s_icb_cmd_wdata,
   output logic [P_DATA_WIDTH/8-1:0]           s_icb_cmd_wstrb,
   input  logic                                s_icb_rsp_vld,
   output logic                                s_icb_rsp_rdy,
   input  logic [P_DATA_WIDTH-1:0]             s_icb_rsp_rdata,
   input  logic                                s_icb_rsp_err
);

   localparam int N  = P_ICB_COUNT;
   localparam int N2 = 2 * P_ICB_COUNT;
   localparam int AW = P_ADDR_WIDTH;
   localparam int DW = P_DATA_WIDTH;
   localparam int SW = P_DATA_WIDTH / 8;
   localparam int IW = clog2_min1(P_ICB_COUNT);

   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] lock_idx;
   logic          lock;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] nxt_ptr;
   logic [N2-1:0] dreq;
   logic [N2-1:0] dmask;
   logic [N2-1:0] dsel;
   logic [N2-1:0] dlow;
   logic [N-1:0]  rr_gnt;
   logic [N-1:0]  grant;
   logic          cmd_hsk;
   logic          rsp_hsk;
   logic          fifo_i_rdy;
   logic          fifo_full;
   logic          fifo_vld;
   logic [N-1:0]  head;
   logic [N-1:0]  rsp_sel;

   // Round-robin pick: duplicate the request vector, mask off the
   // low copy below rr_ptr, keep the lowest set bit and fold the two
   // halves back together. That yields the first request at or above
   // rr_ptr with wrap-around, without a priority chain per pointer.
   always_comb begin
      dreq   = {mn_icb_cmd_vld, mn_icb_cmd_vld};
      dmask  = ~((N2'(1) << rr_ptr) - N2'(1));
      dsel   = dreq & dmask;
      dlow   = dsel & (~dsel + N2'(1));
      rr_gnt = dlow[N-1:0] | dlow[N2-1:N];
   end

   // A stalled command pins the grant until it is accepted.
   assign grant = lock ? (N'(1) << lock_idx) : rr_gnt;

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) gnt_idx = gnt_idx | IW'(i);
      end
   end

   assign nxt_ptr = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

   // Full is judged on the registered fill level only, so a
   // response pop never opens the command path in the same cycle.
   assign fifo_full      = ~fifo_i_rdy;
   assign s_icb_cmd_vld  = (|mn_icb_cmd_vld) & ~fifo_full;
   assign mn_icb_cmd_rdy = grant & {N{s_icb_cmd_rdy & ~fifo_full}};
   assign cmd_hsk        = |(mn_icb_cmd_vld & mn_icb_cmd_rdy);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr   <= '0;
         lock     <= 1'b0;
         lock_idx <= '0;
      end else if (cmd_hsk) begin
         rr_ptr <= nxt_ptr;
         lock   <= 1'b0;
      end else if (s_icb_cmd_vld) begin
         lock     <= 1'b1;
         lock_idx <= gnt_idx;
      end
   end

   always_comb begin
      s_icb_cmd_write = 1'b0;
      s_icb_cmd_addr  = '0;
      s_icb_cmd_wdata = '0;
      s_icb_cmd_wstrb = '0;
      for (int i = 0; i < N; i++) begin
         s_icb_cmd_write = s_icb_cmd_write
                         | (grant[i] & mn_icb_cmd_write[i]);
         s_icb_cmd_addr  = s_icb_cmd_addr
                         | (mn_icb_cmd_addr[i*AW +: AW] & {AW{grant[i]}});
         s_icb_cmd_wdata = s_icb_cmd_wdata
                         | (mn_icb_cmd_wdata[i*DW +: DW] & {DW{grant[i]}});
         s_icb_cmd_wstrb = s_icb_cmd_wstrb
                         | (mn_icb_cmd_wstrb[i*SW +: SW] & {SW{grant[i]}});
      end
   end

   lnrv_gnrl_buffer #(
      .P_DATA_WIDTH (N),
      .P_DEEPTH     (P_OTS_COUNT),
      .P_CUT_READY  ("true"),
      .P_BYPASS     ("false")
   ) u_ots_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush_req (1'b0),
      .i_vld     (cmd_hsk),
      .i_rdy     (fifo_i_rdy),
      .i_data    (grant),
      .o_vld     (fifo_vld),
      .o_rdy     (rsp_hsk),
      .o_data    (head)
   );

   // Responses follow command order; with nothing outstanding the
   // slave response is held off indefinitely.
   assign rsp_sel        = head & {N{fifo_vld}};
   assign mn_icb_rsp_vld = rsp_sel & {N{s_icb_rsp_vld}};
   assign s_icb_rsp_rdy  = |(rsp_sel & mn_icb_rsp_rdy);
   assign rsp_hsk        = s_icb_rsp_vld & s_icb_rsp_rdy;
   assign mn_icb_rsp_err = rsp_sel & {N{s_icb_rsp_err}};

   always_comb begin
      mn_icb_rsp_rdata = '0;
      for (int i = 0; i < N; i++) begin
         mn_icb_rsp_rdata[i*DW +: DW] = s_icb_rsp_rdata & {DW{rsp_sel[i]}};
      end
   end

endmodule

// File: tb/tb_lnrv_icb_arbiter.sv
// Directed bench for the 4-master ICB arbiter, two outstanding.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_lnrv_icb_arbiter;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [3:0]   mn_icb_cmd_vld;
   logic [3:0]   mn_icb_cmd_rdy;
   logic [3:0]   mn_icb_cmd_write;
   logic [127:0] mn_icb_cmd_addr;
   logic [127:0] mn_icb_cmd_wdata;
   logic [15:0]  mn_icb_cmd_wstrb;
   logic [3:0]   mn_icb_rsp_vld;
   logic [3:0]   mn_icb_rsp_rdy;
   logic [127:0] mn_icb_rsp_rdata;
   logic [3:0]   mn_icb_rsp_err;
   logic         s_icb_cmd_vld;
   logic         s_icb_cmd_rdy;
   logic         s_icb_cmd_write;
   logic [31:0]  s_icb_cmd_addr;
   logic [31:0]  s_icb_cmd_wdata;
   logic [3:0]   s_icb_cmd_wstrb;
   logic         s_icb_rsp_vld;
   logic         s_icb_rsp_rdy;
   logic [31:0]  s_icb_rsp_rdata;
   logic         s_icb_rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lnrv_icb_arbiter #(
      .P_ADDR_WIDTH (32),
      .P_DATA_WIDTH (32),
      .P_ICB_COUNT  (4),
      .P_OTS_COUNT  (2)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mn_icb_cmd_vld   (mn_icb_cmd_vld),
      .mn_icb_cmd_rdy   (mn_icb_cmd_rdy),
      .mn_icb_cmd_write (mn_icb_cmd_write),
      .mn_icb_cmd_addr  (mn_icb_cmd_addr),
      .mn_icb_cmd_wdata (mn_icb_cmd_wdata),
      .mn_icb_cmd_wstrb (mn_icb_cmd_wstrb),
      .mn_icb_rsp_vld   (mn_icb_rsp_vld),
      .mn_icb_rsp_rdy   (mn_icb_rsp_rdy),
      .mn_icb_rsp_rdata (mn_icb_rsp_rdata),
      .mn_icb_rsp_err   (mn_icb_rsp_err),
      .s_icb_cmd_vld    (s_icb_cmd_vld),
      .s_icb_cmd_rdy    (s_icb_cmd_rdy),
      .s_icb_cmd_write  (s_icb_cmd_write),
      .s_icb_cmd_addr   (s_icb_cmd_addr),
      .s_icb_cmd_wdata  (s_icb_cmd_wdata),
      .s_icb_cmd_wstrb  (s_icb_cmd_wstrb),
      .s_icb_rsp_vld    (s_icb_rsp_vld),
      .s_icb_rsp_rdy    (s_icb_rsp_rdy),
      .s_icb_rsp_rdata  (s_icb_rsp_rdata),
      .s_icb_rsp_err    (s_icb_rsp_err)
   );

   // Master i always presents address 0x100*(i+1) so the merged
   // address identifies the granted master.
   task automatic clear_inputs;
      mn_icb_cmd_vld   = '0;
      mn_icb_cmd_write = '0;
      mn_icb_cmd_wdata = '0;
      mn_icb_cmd_wstrb = '0;
      mn_icb_rsp_rdy   = '0;
      for (int i = 0; i < 4; i++)
         mn_icb_cmd_addr[i*32 +: 32] = 32'(256 * (i + 1));
      s_icb_cmd_rdy   = 1'b0;
      s_icb_rsp_vld   = 1'b0;
      s_icb_rsp_rdata = '0;
      s_icb_rsp_err   = 1'b0;
   endtask

   task automatic do_reset;
      clear_inputs();
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      do_reset();
      s_icb_rsp_vld = 1'b1;
      #1;
      n_tests++;
      if (s_icb_cmd_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_cmd_vld got %b exp 0", s_icb_cmd_vld);
      end
      n_tests++;
      if (mn_icb_rsp_vld !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_rsp_vld got %b exp 0000", mn_icb_rsp_vld);
      end
      n_tests++;
      if (s_icb_rsp_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_rsp_rdy got %b exp 0", s_icb_rsp_rdy);
      end
      n_tests++;
      if (s_icb_cmd_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_addr got %h exp 0", s_icb_cmd_addr);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (s_icb_rsp_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL empty_rsp_held got %b exp 0", s_icb_rsp_rdy);
      end
   endtask

   task automatic test_single_write;
      do_reset();
      mn_icb_cmd_vld   = 4'b0001;
      mn_icb_cmd_write = 4'b0001;
      mn_icb_cmd_addr[31:0]  = 32'h0000_1000;
      mn_icb_cmd_wdata[31:0] = 32'hA5A5_A5A5;
      mn_icb_cmd_wstrb[3:0]  = 4'hF;
      mn_icb_rsp_rdy = 4'b1111;
      s_icb_cmd_rdy  = 1'b1;
      s_icb_rsp_vld  = 1'b1;
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0001) begin
         n_fail++;
         $display("FAIL t1_cmd_rdy got %b exp 0001", mn_icb_cmd_rdy);
      end
      n_tests++;
      if ({s_icb_cmd_vld, s_icb_cmd_write, s_icb_cmd_addr,
           s_icb_cmd_wdata, s_icb_cmd_wstrb}
          !== {1'b1, 1'b1, 32'h1000, 32'hA5A5A5A5, 4'hF}) begin
         n_fail++;
         $display("FAIL t1_payload got %b %b %h %h %h exp 1 1 1000 a5a5a5a5 f",
                  s_icb_cmd_vld, s_icb_cmd_write, s_icb_cmd_addr,
                  s_icb_cmd_wdata, s_icb_cmd_wstrb);
      end
      n_tests++;
      if (s_icb_rsp_rdy !== 1'b0 || mn_icb_rsp_vld !== 4'b0000) begin
         n_fail++;
         $display("FAIL t1_no_bypass got rdy %b vld %b exp 0 0000",
                  s_icb_rsp_rdy, mn_icb_rsp_vld);
      end
      @(negedge clk);
      mn_icb_cmd_vld = 4'b0000;
      #1;
      n_tests++;
      if (mn_icb_rsp_vld !== 4'b0001 || s_icb_rsp_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL t1_rsp got vld %b rdy %b exp 0001 1",
                  mn_icb_rsp_vld, s_icb_rsp_rdy);
      end
      n_tests++;
      if (mn_icb_rsp_rdata !== 128'h0) begin
         n_fail++;
         $display("FAIL t1_rdata got %h exp 0", mn_icb_rsp_rdata);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (mn_icb_rsp_vld !== 4'b0000 || s_icb_rsp_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_popped got vld %b rdy %b exp 0000 0",
                  mn_icb_rsp_vld, s_icb_rsp_rdy);
      end
   endtask

   task automatic test_round_robin;
      int e [6] = '{0, 1, 2, 0, 1, 2};
      do_reset();
      mn_icb_cmd_vld = 4'b0111;
      mn_icb_rsp_rdy = 4'b1111;
      s_icb_cmd_rdy  = 1'b1;
      s_icb_rsp_vld  = 1'b1;
      for (int j = 0; j < 6; j++) begin
         #1;
         n_tests++;
         if (mn_icb_cmd_rdy !== 4'(1 << e[j])) begin
            n_fail++;
            $display("FAIL rr_grant[%0d] got %b exp %b",
                     j, mn_icb_cmd_rdy, 4'(1 << e[j]));
         end
         n_tests++;
         if (s_icb_cmd_addr !== 32'(256 * (e[j] + 1))) begin
            n_fail++;
            $display("FAIL rr_addr[%0d] got %h exp %h",
                     j, s_icb_cmd_addr, 32'(256 * (e[j] + 1)));
         end
         if (j > 0) begin
            n_tests++;
            if (mn_icb_rsp_vld !== 4'(1 << e[j-1])) begin
               n_fail++;
               $display("FAIL rr_rsp[%0d] got %b exp %b",
                        j, mn_icb_rsp_vld, 4'(1 << e[j-1]));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lock;
      do_reset();
      mn_icb_cmd_vld = 4'b0100;
      for (int j = 0; j < 3; j++) begin
         #1;
         n_tests++;
         if (s_icb_cmd_addr !== 32'h300 || mn_icb_cmd_rdy !== 4'b0000
             || s_icb_cmd_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_hold[%0d] got addr %h rdy %b vld %b exp 300 0000 1",
                     j, s_icb_cmd_addr, mn_icb_cmd_rdy, s_icb_cmd_vld);
         end
         @(negedge clk);
         mn_icb_cmd_vld = 4'b0110;
      end
      s_icb_cmd_rdy = 1'b1;
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0100) begin
         n_fail++;
         $display("FAIL lock_hsk got %b exp 0100", mn_icb_cmd_rdy);
      end
      @(negedge clk);
      mn_icb_cmd_vld = 4'b0010;
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0010 || s_icb_cmd_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL lock_release got rdy %b addr %h exp 0010 200",
                  mn_icb_cmd_rdy, s_icb_cmd_addr);
      end
      @(negedge clk);
   endtask

   task automatic test_ots_full;
      do_reset();
      mn_icb_cmd_vld = 4'b0011;
      mn_icb_rsp_rdy = 4'b1111;
      s_icb_cmd_rdy  = 1'b1;
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0001) begin
         n_fail++;
         $display("FAIL ots_c0 got %b exp 0001", mn_icb_cmd_rdy);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0010) begin
         n_fail++;
         $display("FAIL ots_c1 got %b exp 0010", mn_icb_cmd_rdy);
      end
      @(negedge clk);
      s_icb_rsp_vld = 1'b1;
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0000 || s_icb_cmd_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL ots_full got rdy %b vld %b exp 0000 0",
                  mn_icb_cmd_rdy, s_icb_cmd_vld);
      end
      n_tests++;
      if (mn_icb_rsp_vld !== 4'b0001 || s_icb_rsp_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL ots_pop got vld %b rdy %b exp 0001 1",
                  mn_icb_rsp_vld, s_icb_rsp_rdy);
      end
      @(negedge clk);
      s_icb_rsp_vld = 1'b0;
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0001) begin
         n_fail++;
         $display("FAIL ots_resume got %b exp 0001", mn_icb_cmd_rdy);
      end
      @(negedge clk);
   endtask

   task automatic test_rsp_hold;
      do_reset();
      s_icb_cmd_rdy  = 1'b1;
      mn_icb_cmd_vld = 4'b0010;
      @(negedge clk);
      mn_icb_cmd_vld = 4'b1000;
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b1000) begin
         n_fail++;
         $display("FAIL hold_m3_cmd got %b exp 1000", mn_icb_cmd_rdy);
      end
      @(negedge clk);
      mn_icb_cmd_vld  = 4'b0000;
      s_icb_rsp_vld   = 1'b1;
      s_icb_rsp_rdata = 32'hDEAD_BEEF;
      for (int j = 0; j < 2; j++) begin
         #1;
         n_tests++;
         if (mn_icb_rsp_vld !== 4'b0010 || s_icb_rsp_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_wait[%0d] got vld %b rdy %b exp 0010 0",
                     j, mn_icb_rsp_vld, s_icb_rsp_rdy);
         end
         n_tests++;
         if (mn_icb_rsp_rdata[63:32] !== 32'hDEADBEEF
             || mn_icb_rsp_rdata[127:96] !== 32'h0) begin
            n_fail++;
            $display("FAIL hold_data[%0d] got m1 %h m3 %h exp deadbeef 0",
                     j, mn_icb_rsp_rdata[63:32], mn_icb_rsp_rdata[127:96]);
         end
         @(negedge clk);
      end
      mn_icb_rsp_rdy = 4'b0010;
      #1;
      n_tests++;
      if (s_icb_rsp_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_m1_acc got %b exp 1", s_icb_rsp_rdy);
      end
      @(negedge clk);
      s_icb_rsp_rdata = 32'hCAFE_F00D;
      s_icb_rsp_err   = 1'b1;
      mn_icb_rsp_rdy  = 4'b1000;
      #1;
      n_tests++;
      if (mn_icb_rsp_vld !== 4'b1000 || mn_icb_rsp_err !== 4'b1000
          || s_icb_rsp_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_m3_rsp got vld %b err %b rdy %b exp 1000 1000 1",
                  mn_icb_rsp_vld, mn_icb_rsp_err, s_icb_rsp_rdy);
      end
      n_tests++;
      if (mn_icb_rsp_rdata[127:96] !== 32'hCAFEF00D
          || mn_icb_rsp_rdata[63:32] !== 32'h0) begin
         n_fail++;
         $display("FAIL hold_m3_data got m3 %h m1 %h exp cafef00d 0",
                  mn_icb_rsp_rdata[127:96], mn_icb_rsp_rdata[63:32]);
      end
      @(negedge clk);
      s_icb_rsp_vld  = 1'b0;
      s_icb_rsp_err  = 1'b0;
      mn_icb_cmd_vld = 4'b1011;
      #1;
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0001 || mn_icb_rsp_vld !== 4'b0000) begin
         n_fail++;
         $display("FAIL wrap_ptr got rdy %b rsp %b exp 0001 0000",
                  mn_icb_cmd_rdy, mn_icb_rsp_vld);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      do_reset();
      mn_icb_cmd_vld = 4'b0011;
      s_icb_cmd_rdy  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      mn_icb_cmd_vld = 4'b0000;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      mn_icb_cmd_vld = 4'b0101;
      mn_icb_rsp_rdy = 4'b1111;
      s_icb_rsp_vld  = 1'b1;
      #1;
      n_tests++;
      if (mn_icb_rsp_vld !== 4'b0000 || s_icb_rsp_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst_rsp got vld %b rdy %b exp 0000 0",
                  mn_icb_rsp_vld, s_icb_rsp_rdy);
      end
      n_tests++;
      if (mn_icb_cmd_rdy !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_rst_grant got %b exp 0001", mn_icb_cmd_rdy);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_lock();
      test_ots_full();
      test_rsp_hold();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
